// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// constant-function clog2 used to size the bit index.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// 1-bit full adder cell used by the serial adder datapath.
module fulladder (
    input  logic in_a,
    input  logic in_b,
    input  logic in_ci,
    output logic out_s,
    output logic out_co
);

    assign out_s  = in_a ^ in_b ^ in_ci;
    assign out_co = (in_a & in_b) | (in_a & in_ci) | (in_b & in_ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle, LSB first, through a single
// full-adder cell; result, carry-out and overflow are registered at the end.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_busy,
    output logic             out_done
);

    localparam int IDX_W = clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] s_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic             co_reg;
    logic             ovf_reg;
    logic             done_reg;

    logic [WIDTH-1:0] bit_sel;
    logic             run;
    logic             last_bit;
    logic             bit_a;
    logic             bit_b;
    logic             fa_s;
    logic             fa_co;

    assign run      = (state_reg == ST_RUN);
    assign last_bit = (idx_reg == LAST_IDX);

    // One-hot decode of the bit index drives both operand selection and the
    // result write-back, so no variable part-select is needed.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bit_sel[gi]  = (idx_reg == IDX_W'(gi));
            assign res_next[gi] = (run && bit_sel[gi]) ? fa_s : res_reg[gi];
        end
    endgenerate

    assign bit_a = |(a_reg & bit_sel);
    assign bit_b = |(b_reg & bit_sel);

    fulladder u_fa (
        .in_a   (bit_a),
        .in_b   (bit_b),
        .in_ci  (carry_reg),
        .out_s  (fa_s),
        .out_co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (in_start) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_ci;
                        idx_reg   <= '0;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_reg   <= res_next;
                    carry_reg <= fa_co;
                    if (last_bit) begin
                        // carry_reg still holds the carry into the MSB here
                        state_reg <= ST_DONE;
                        s_reg     <= res_next;
                        co_reg    <= fa_co;
                        ovf_reg   <= carry_reg ^ fa_co;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_s    = s_reg;
    assign out_co   = co_reg;
    assign out_ovf  = ovf_reg;
    assign out_busy = run;
    assign out_done = done_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three serial_adder instances (WIDTH 8, 2, 32) against a
// cycle-level arithmetic model, plus directed literal scenarios.
module tb_serial_adder;

    localparam int NCH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   wv [NCH] = '{8, 2, 32};

    logic [NCH-1:0] start_v;
    logic [NCH-1:0] ci_v;
    logic [31:0]    a_v [NCH];
    logic [31:0]    b_v [NCH];

    logic [7:0]     s8;
    logic [1:0]     s2;
    logic [31:0]    s32;
    logic [NCH-1:0] co_v;
    logic [NCH-1:0] ovf_v;
    logic [NCH-1:0] busy_v;
    logic [NCH-1:0] done_v;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_start(start_v[0]),
        .in_a(a_v[0][7:0]), .in_b(b_v[0][7:0]), .in_ci(ci_v[0]),
        .out_s(s8), .out_co(co_v[0]), .out_ovf(ovf_v[0]),
        .out_busy(busy_v[0]), .out_done(done_v[0])
    );

    serial_adder #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_start(start_v[1]),
        .in_a(a_v[1][1:0]), .in_b(b_v[1][1:0]), .in_ci(ci_v[1]),
        .out_s(s2), .out_co(co_v[1]), .out_ovf(ovf_v[1]),
        .out_busy(busy_v[1]), .out_done(done_v[1])
    );

    serial_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_start(start_v[2]),
        .in_a(a_v[2]), .in_b(b_v[2]), .in_ci(ci_v[2]),
        .out_s(s32), .out_co(co_v[2]), .out_ovf(ovf_v[2]),
        .out_busy(busy_v[2]), .out_done(done_v[2])
    );

    function automatic logic [31:0] get_s(input int ch);
        if (ch == 0) return {24'd0, s8};
        if (ch == 1) return {30'd0, s2};
        return s32;
    endfunction

    task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s ch%0d: got %0h, expected %0h (t=%0t)", name, ch, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: unsigned sum split into carry/sum, overflow
    // from the signed interpretation of the operands.
    function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                                    output logic [31:0] s, output logic co, output logic ovf);
        longint unsigned mask, ua, ub, sum;
        longint h, sa, sb, ts;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sum  = ua + ub + {63'd0, ci};
        s    = 32'(sum & mask);
        co   = 1'((sum >> w) & 64'd1);
        h    = longint'(1) << (w - 1);
        sa   = (longint'(ua) >= h) ? longint'(ua) - 2 * h : longint'(ua);
        sb   = (longint'(ub) >= h) ? longint'(ub) - 2 * h : longint'(ub);
        ts   = sa + sb + longint'(ci);
        ovf  = (ts >= h) || (ts < -h);
    endfunction

    // Cycle model: edge counter, accepted-start edge and pending result per channel.
    longint      cyc = 0;
    longint      k_acc   [NCH];
    longint      done_at [NCH];
    bit          active  [NCH];
    logic [31:0] m_s     [NCH];
    logic        m_co    [NCH];
    logic        m_ovf   [NCH];
    logic [31:0] p_s     [NCH];
    logic        p_co    [NCH];
    logic        p_ovf   [NCH];
    bit          busy_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                active[ch]  = 1'b0;
                done_at[ch] = -1;
                k_acc[ch]   = 0;
                m_s[ch]     = '0;
                m_co[ch]    = 1'b0;
                m_ovf[ch]   = 1'b0;
            end
        end else begin
            cyc = cyc + 1;
            for (int ch = 0; ch < NCH; ch++) begin
                busy_prev = active[ch] && (cyc - 1 >= k_acc[ch]) && (cyc - 1 < k_acc[ch] + wv[ch]);
                if (active[ch] && cyc == k_acc[ch] + wv[ch]) begin
                    m_s[ch]     = p_s[ch];
                    m_co[ch]    = p_co[ch];
                    m_ovf[ch]   = p_ovf[ch];
                    done_at[ch] = cyc;
                end
                if (start_v[ch] && !busy_prev) begin
                    k_acc[ch]  = cyc;
                    active[ch] = 1'b1;
                    ref_add(wv[ch], a_v[ch], b_v[ch], ci_v[ch], p_s[ch], p_co[ch], p_ovf[ch]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                logic exp_busy, exp_done;
                exp_busy = active[ch] && (cyc >= k_acc[ch]) && (cyc < k_acc[ch] + wv[ch]);
                exp_done = (done_at[ch] == cyc);
                chk("busy", ch, 64'(busy_v[ch]), 64'(exp_busy));
                chk("done", ch, 64'(done_v[ch]), 64'(exp_done));
                chk("s",    ch, 64'(get_s(ch)),  64'(m_s[ch]));
                chk("co",   ch, 64'(co_v[ch]),   64'(m_co[ch]));
                chk("ovf",  ch, 64'(ovf_v[ch]),  64'(m_ovf[ch]));
                if (exp_done)
                    $display("ch%0d W=%0d result at cycle %0d: s=%h co=%b ovf=%b",
                             ch, wv[ch], cyc, get_s(ch), co_v[ch], ovf_v[ch]);
            end
        end
    end

    // Start one addition at the current negedge, wait (bounded) for done and
    // check literal expectations. inject_at>0 pulses a stray start mid-run.
    task automatic run_add(input int ch, input logic [31:0] a, input logic [31:0] b, input logic ci,
                           input logic [31:0] es, input logic eco, input logic eovf,
                           input int inject_at, output longint done_cyc);
        longint k;
        int     busy_cnt;
        bit     seen;
        start_v[ch] = 1'b1;
        a_v[ch] = a;
        b_v[ch] = b;
        ci_v[ch] = ci;
        @(negedge clk);
        k = cyc;
        start_v[ch] = 1'b0;
        a_v[ch] = $urandom;
        b_v[ch] = $urandom;
        ci_v[ch] = 1'($urandom);
        busy_cnt = 0;
        seen = 1'b0;
        done_cyc = -1;
        for (int n = 1; n <= wv[ch] + 4 && !seen; n++) begin
            if (busy_v[ch]) busy_cnt++;
            if (done_v[ch]) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                if (n == inject_at) begin
                    start_v[ch] = 1'b1;
                    a_v[ch] = 32'h11;
                    b_v[ch] = 32'h11;
                end else begin
                    start_v[ch] = 1'b0;
                end
                @(negedge clk);
            end
        end
        start_v[ch] = 1'b0;
        chk("done_seen",   ch, 64'(seen), 64'd1);
        chk("latency",     ch, 64'(done_cyc - k + 1), 64'(wv[ch] + 1));
        chk("busy_cycles", ch, 64'(busy_cnt), 64'(wv[ch]));
        chk("sum_lit",     ch, 64'(get_s(ch)), 64'(es));
        chk("co_lit",      ch, 64'(co_v[ch]), 64'(eco));
        chk("ovf_lit",     ch, 64'(ovf_v[ch]), 64'(eovf));
    endtask

    task automatic check_zero(input int ch, input string tag);
        chk({tag, "_s"},    ch, 64'(get_s(ch)), 64'd0);
        chk({tag, "_co"},   ch, 64'(co_v[ch]),  64'd0);
        chk({tag, "_ovf"},  ch, 64'(ovf_v[ch]), 64'd0);
        chk({tag, "_busy"}, ch, 64'(busy_v[ch]), 64'd0);
        chk({tag, "_done"}, ch, 64'(done_v[ch]), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint d1, d2, dc;
        logic [1:0] s_e;
        logic       co_e, ovf_e;
        int         tot, sa, sb, ts;

        rst_n = 1'b0;
        start_v = '0;
        ci_v = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            a_v[ch] = '0;
            b_v[ch] = '0;
        end
        #1;
        for (int ch = 0; ch < NCH; ch++) check_zero(ch, "reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // W=8 zero operands, then carry and overflow back-to-back
        run_add(0, 32'h00, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0, -1, dc);
        repeat (2) @(negedge clk);
        run_add(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, -1, d1);
        run_add(0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, -1, d2);
        chk("done_spacing", 0, 64'(d2 - d1), 64'd9);

        // stray start during RUN must be ignored
        repeat (2) @(negedge clk);
        run_add(0, 32'h0F, 32'hF0, 1'b1, 32'h00, 1'b1, 1'b0, 3, dc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_extra_done", 0, 64'(done_v[0]), 64'd0);
        end

        // reset mid-run aborts without a done pulse
        start_v[0] = 1'b1;
        a_v[0] = 32'hAA;
        b_v[0] = 32'h55;
        ci_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero(0, "midrun_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("aborted_done", 0, 64'(done_v[0]), 64'd0);
        end
        run_add(0, 32'h01, 32'h02, 1'b0, 32'h03, 1'b0, 1'b0, -1, dc);

        // W=2 exhaustive sweep, back-to-back
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    tot   = a + b + c;
                    s_e   = 2'(tot);
                    co_e  = (tot >= 4);
                    sa    = (a >= 2) ? a - 4 : a;
                    sb    = (b >= 2) ? b - 4 : b;
                    ts    = sa + sb + c;
                    ovf_e = (ts > 1) || (ts < -2);
                    run_add(1, 32'(a), 32'(b), 1'(c), {30'd0, s_e}, co_e, ovf_e, -1, dc);
                end
            end
        end

        // W=32 full-carry case
        repeat (2) @(negedge clk);
        run_add(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, dc);

        // random traffic on all channels, with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
                @(negedge clk);
            end
            for (int ch = 0; ch < NCH; ch++) begin
                start_v[ch] = ($urandom_range(0, 2) == 0);
                a_v[ch]     = $urandom;
                b_v[ch]     = $urandom;
                ci_v[ch]    = 1'($urandom);
            end
            @(negedge clk);
        end
        start_v = '0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
